spi_csr_bridge_ctrl: RTL and testbench

SPI_CSR_BRIDGE_CTRL -- requirements
Module: spi_csr_bridge_ctrl

---
 rtl/spi_csr_bridge_ctrl.sv | 161 ++++++++++++++++
 tb/tb_spi_csr_bridge_ctrl.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_csr_bridge_ctrl.sv
// Host CSR front-end that drives Avalon-MM accesses into an SPI bridge.
// Optional access timeout is enabled with `define SPI_BRIDGE_TIMEOUT_EN.
module spi_csr_bridge_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        csr_wr,
  input  logic        csr_rd,
  input  logic [5:0]  csr_addr,
  input  logic [63:0] csr_wdata,
  output logic [63:0] csr_rdata,
  output logic        csr_rvalid,
  output logic [2:0]  avmm_address,
  output logic        avmm_write,
  output logic        avmm_read,
  output logic [31:0] avmm_writedata,
  input  logic        avmm_waitrequest,
  input  logic [31:0] avmm_readdata,
  input  logic        avmm_readdatavalid
);

  typedef enum logic [1:0] {
    IDLE, WR_REQ, RD_REQ, RD_WAIT
  } state_t;

  state_t      state;
  logic [1:0]  rst_sync;
  logic        rst_i;
  logic [31:0] wd_reg;
  logic [31:0] rd_data;
  logic [2:0]  target;
  logic        cmd_drop;
  logic        cmd_conf;
  logic        to_err;
  logic        to_hit;
  logic        busy;
  logic        ctrl_we;
  logic        wd_we;
  logic        wr_cmd;
  logic        rd_cmd;
  logic        drop_set;
  logic        conf_set;
  logic [63:0] ctrl_val;
  logic [63:0] rd_mux;

  // Assert asynchronously, release on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_i = rst_sync[1];

  assign busy     = (state != IDLE);
  assign ctrl_we  = csr_wr && (csr_addr == 6'h10);
  assign wd_we    = csr_wr && (csr_addr == 6'h20);
  assign wr_cmd   = csr_wdata[8];
  assign rd_cmd   = csr_wdata[9];
  assign drop_set = ctrl_we && busy && (wr_cmd || rd_cmd);
  assign conf_set = ctrl_we && !busy && wr_cmd && rd_cmd;

`ifdef SPI_BRIDGE_TIMEOUT_EN
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] to_cnt;
  assign to_hit = busy && (to_cnt == TO_LIMIT);
`else
  assign to_hit = 1'b0;
  assign to_err = 1'b0;
`endif

  assign ctrl_val = {44'b0, cmd_conf, cmd_drop, to_err, busy,
                     13'b0, target};

  always_comb begin
    rd_mux = '0;
    case (csr_addr)
      6'h10:   rd_mux = ctrl_val;
      6'h18:   rd_mux = {32'b0, rd_data};
      6'h20:   rd_mux = {32'b0, wd_reg};
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      state          <= IDLE;
      csr_rdata      <= '0;
      csr_rvalid     <= 1'b0;
      avmm_address   <= '0;
      avmm_write     <= 1'b0;
      avmm_read      <= 1'b0;
      avmm_writedata <= '0;
      wd_reg         <= '0;
      rd_data        <= '0;
      target         <= '0;
      cmd_drop       <= 1'b0;
      cmd_conf       <= 1'b0;
`ifdef SPI_BRIDGE_TIMEOUT_EN
      to_err         <= 1'b0;
      to_cnt         <= '0;
`endif
    end else begin
      csr_rvalid <= csr_rd;
      csr_rdata  <= csr_rd ? rd_mux : '0;
      if (wd_we)   wd_reg <= csr_wdata[31:0];
      if (ctrl_we) target <= csr_wdata[2:0];
      // A set in the same cycle as its W1C clear wins.
      cmd_drop <= (cmd_drop & ~(ctrl_we & csr_wdata[18])) | drop_set;
      cmd_conf <= (cmd_conf & ~(ctrl_we & csr_wdata[19])) | conf_set;
`ifdef SPI_BRIDGE_TIMEOUT_EN
      to_err <= (to_err & ~(ctrl_we & csr_wdata[17])) | to_hit;
      to_cnt <= busy && !to_hit ? to_cnt + 16'd1 : '0;
`endif
      if (to_hit) begin
        avmm_write <= 1'b0;
        avmm_read  <= 1'b0;
        rd_data    <= 32'hDEAD_BEEF;
        state      <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (ctrl_we && wr_cmd && !rd_cmd) begin
              avmm_address   <= csr_wdata[2:0];
              avmm_writedata <= wd_reg;
              avmm_write     <= 1'b1;
              state          <= WR_REQ;
            end else if (ctrl_we && rd_cmd && !wr_cmd) begin
              avmm_address <= csr_wdata[2:0];
              avmm_read    <= 1'b1;
              state        <= RD_REQ;
            end
          end
          WR_REQ: begin
            if (!avmm_waitrequest) begin
              avmm_write <= 1'b0;
              state      <= IDLE;
            end
          end
          RD_REQ: begin
            if (!avmm_waitrequest) begin
              avmm_read <= 1'b0;
              if (avmm_readdatavalid) begin
                rd_data <= avmm_readdata;
                state   <= IDLE;
              end else begin
                state <= RD_WAIT;
              end
            end
          end
          RD_WAIT: begin
            if (avmm_readdatavalid) begin
              rd_data <= avmm_readdata;
              state   <= IDLE;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_csr_bridge_ctrl.sv
// Directed self-checking bench for spi_csr_bridge_ctrl.
// Timeout scenario adapts to `define SPI_BRIDGE_TIMEOUT_EN.
module tb_spi_csr_bridge_ctrl;

  logic        clk;
  logic        rst_n;
  logic        csr_wr;
  logic        csr_rd;
  logic [5:0]  csr_addr;
  logic [63:0] csr_wdata;
  logic [63:0] csr_rdata;
  logic        csr_rvalid;
  logic [2:0]  avmm_address;
  logic        avmm_write;
  logic        avmm_read;
  logic [31:0] avmm_writedata;
  logic        avmm_waitrequest;
  logic [31:0] avmm_readdata;
  logic        avmm_readdatavalid;

  int n_chk;
  int n_pass;
  int wr_acc;
  int rd_acc;
  logic [2:0]  acc_addr;
  logic [31:0] acc_data;

  spi_csr_bridge_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .csr_wr             (csr_wr),
    .csr_rd             (csr_rd),
    .csr_addr           (csr_addr),
    .csr_wdata          (csr_wdata),
    .csr_rdata          (csr_rdata),
    .csr_rvalid         (csr_rvalid),
    .avmm_address       (avmm_address),
    .avmm_write         (avmm_write),
    .avmm_read          (avmm_read),
    .avmm_writedata     (avmm_writedata),
    .avmm_waitrequest   (avmm_waitrequest),
    .avmm_readdata      (avmm_readdata),
    .avmm_readdatavalid (avmm_readdatavalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count accepted Avalon transfers.
  always @(posedge clk) begin
    if (avmm_write && !avmm_waitrequest) begin
      wr_acc++;
      acc_addr = avmm_address;
      acc_data = avmm_writedata;
    end
    if (avmm_read && !avmm_waitrequest) rd_acc++;
  end

  task automatic csr_write(input logic [5:0] a, input logic [63:0] d);
    @(negedge clk);
    csr_wr    = 1'b1;
    csr_addr  = a;
    csr_wdata = d;
    @(negedge clk);
    csr_wr    = 1'b0;
    csr_wdata = '0;
  endtask

  task automatic csr_read(input logic [5:0] a,
                          output logic [63:0] d, output logic v);
    @(negedge clk);
    csr_rd   = 1'b1;
    csr_addr = a;
    @(negedge clk);
    csr_rd = 1'b0;
    d = csr_rdata;
    v = csr_rvalid;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [63:0] d;
    logic v;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({avmm_write, avmm_read, avmm_address, avmm_writedata,
         csr_rvalid, csr_rdata} !== '0)
      $display("FAIL reset_outputs got w=%b r=%b a=%h d=%h rv=%b rd=%h want all 0",
               avmm_write, avmm_read, avmm_address, avmm_writedata,
               csr_rvalid, csr_rdata);
    else n_pass++;
    release_reset();
    csr_read(6'h10, d, v);
    n_chk++;
    if (d !== 64'h0 || v !== 1'b1)
      $display("FAIL reset_control got %h v=%b want 0 v=1", d, v);
    else n_pass++;
    csr_read(6'h18, d, v);
    n_chk++;
    if (d !== 64'h0) $display("FAIL reset_readdata got %h want 0", d);
    else n_pass++;
  endtask

  task automatic test_csr_regs();
    logic [63:0] d;
    logic v;
    csr_write(6'h20, 64'hFFFF_FFFF_1234_ABCD);
    csr_read(6'h20, d, v);
    n_chk++;
    if (d !== 64'h0000_0000_1234_ABCD || v !== 1'b1)
      $display("FAIL writedata_rb got %h v=%b want 1234abcd v=1", d, v);
    else n_pass++;
    csr_write(6'h08, 64'hFFFF_FFFF_FFFF_FFFF);
    csr_read(6'h08, d, v);
    n_chk++;
    if (d !== 64'h0 || v !== 1'b1)
      $display("FAIL unmapped_rd got %h v=%b want 0 v=1", d, v);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (csr_rvalid !== 1'b0)
      $display("FAIL rvalid_pulse got %b want 0", csr_rvalid);
    else n_pass++;
  endtask

  task automatic test_write();
    logic [63:0] d;
    logic v;
    wr_acc = 0;
    rd_acc = 0;
    avmm_waitrequest = 1'b0;
    csr_write(6'h20, 64'h0000_00A5);
    csr_write(6'h10, 64'h101);
    repeat (3) @(negedge clk);
    n_chk++;
    if (wr_acc !== 1 || rd_acc !== 0 || acc_addr !== 3'd1 || acc_data !== 32'hA5)
      $display("FAIL write_access got n=%0d rn=%0d a=%0d d=%h want 1 0 1 a5",
               wr_acc, rd_acc, acc_addr, acc_data);
    else n_pass++;
    csr_read(6'h10, d, v);
    n_chk++;
    if (d[16] !== 1'b0) $display("FAIL write_busy got %b want 0", d[16]);
    else n_pass++;
  endtask

  task automatic test_read();
    logic [63:0] d;
    logic v;
    rd_acc = 0;
    avmm_waitrequest = 1'b1;
    csr_write(6'h10, 64'h202);
    repeat (3) @(negedge clk);
    n_chk++;
    if (avmm_read !== 1'b1 || avmm_address !== 3'd2 || rd_acc !== 0)
      $display("FAIL read_stall got r=%b a=%0d n=%0d want 1 2 0",
               avmm_read, avmm_address, rd_acc);
    else n_pass++;
    avmm_waitrequest = 1'b0;
    @(negedge clk);
    @(negedge clk);
    avmm_readdatavalid = 1'b1;
    avmm_readdata      = 32'h1234_5678;
    @(negedge clk);
    avmm_readdatavalid = 1'b0;
    avmm_readdata      = '0;
    csr_read(6'h18, d, v);
    n_chk++;
    if (d !== 64'h1234_5678 || rd_acc !== 1)
      $display("FAIL read_data got %h n=%0d want 12345678 1", d, rd_acc);
    else n_pass++;
  endtask

  task automatic test_drop();
    logic [63:0] d;
    logic v;
    wr_acc = 0;
    rd_acc = 0;
    avmm_waitrequest = 1'b0;
    csr_write(6'h10, 64'h203);
    @(negedge clk);
    csr_write(6'h10, 64'h100);
    repeat (2) @(negedge clk);
    n_chk++;
    if (wr_acc !== 0 || rd_acc !== 1 || avmm_write !== 1'b0)
      $display("FAIL drop_noaccess got wn=%0d rn=%0d w=%b want 0 1 0",
               wr_acc, rd_acc, avmm_write);
    else n_pass++;
    csr_read(6'h10, d, v);
    n_chk++;
    if (d[18] !== 1'b1 || d[16] !== 1'b1)
      $display("FAIL drop_flag got drop=%b busy=%b want 1 1", d[18], d[16]);
    else n_pass++;
    avmm_readdatavalid = 1'b1;
    avmm_readdata      = 32'hCAFE_F00D;
    @(negedge clk);
    avmm_readdatavalid = 1'b0;
    csr_read(6'h18, d, v);
    n_chk++;
    if (d !== 64'hCAFE_F00D)
      $display("FAIL drop_rddata got %h want cafef00d", d);
    else n_pass++;
    csr_write(6'h10, 64'h4_0000);
    csr_read(6'h10, d, v);
    n_chk++;
    if (d !== 64'h0) $display("FAIL drop_w1c got %h want 0", d);
    else n_pass++;
  endtask

  task automatic test_conflict();
    logic [63:0] d;
    logic v;
    wr_acc = 0;
    rd_acc = 0;
    csr_write(6'h10, 64'h300);
    repeat (3) @(negedge clk);
    csr_read(6'h10, d, v);
    n_chk++;
    if (wr_acc !== 0 || rd_acc !== 0 || d !== 64'h8_0000)
      $display("FAIL conflict got wn=%0d rn=%0d ctrl=%h want 0 0 80000",
               wr_acc, rd_acc, d);
    else n_pass++;
    csr_write(6'h10, 64'h8_0000);
    csr_read(6'h10, d, v);
    n_chk++;
    if (d !== 64'h0) $display("FAIL conflict_w1c got %h want 0", d);
    else n_pass++;
  endtask

  task automatic test_wd_while_busy();
    logic [63:0] d;
    logic v;
    wr_acc = 0;
    avmm_waitrequest = 1'b1;
    csr_write(6'h20, 64'hA5);
    csr_write(6'h10, 64'h105);
    csr_write(6'h20, 64'h5A);
    n_chk++;
    if (avmm_write !== 1'b1 || avmm_address !== 3'd5 ||
        avmm_writedata !== 32'hA5)
      $display("FAIL wd_busy_hold got w=%b a=%0d d=%h want 1 5 a5",
               avmm_write, avmm_address, avmm_writedata);
    else n_pass++;
    avmm_waitrequest = 1'b0;
    @(negedge clk);
    @(negedge clk);
    csr_read(6'h20, d, v);
    n_chk++;
    if (wr_acc !== 1 || acc_data !== 32'hA5 || d !== 64'h5A)
      $display("FAIL wd_busy_done got n=%0d d=%h wd=%h want 1 a5 5a",
               wr_acc, acc_data, d);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [63:0] d;
    logic v;
    avmm_waitrequest = 1'b1;
    csr_write(6'h10, 64'h101);
    csr_write(6'h10, 64'h4_0100);
    csr_read(6'h10, d, v);
    n_chk++;
    if (d[18] !== 1'b1)
      $display("FAIL set_beats_clear got %b want 1", d[18]);
    else n_pass++;
    avmm_waitrequest = 1'b0;
    @(negedge clk);
    csr_write(6'h10, 64'h4_0000);
    csr_read(6'h10, d, v);
    n_chk++;
    if (d !== 64'h0) $display("FAIL b2b_idle got %h want 0", d);
    else n_pass++;
  endtask

  task automatic test_timeout();
    logic [63:0] d;
    logic v;
    avmm_waitrequest = 1'b1;
    csr_write(6'h10, 64'h202);
`ifdef SPI_BRIDGE_TIMEOUT_EN
    repeat (7) @(negedge clk);
    n_chk++;
    if (avmm_read !== 1'b1)
      $display("FAIL timeout_early got %b want 1", avmm_read);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (avmm_read !== 1'b0)
      $display("FAIL timeout_abort got %b want 0", avmm_read);
    else n_pass++;
    avmm_waitrequest = 1'b0;
    csr_read(6'h18, d, v);
    n_chk++;
    if (d !== 64'hDEAD_BEEF)
      $display("FAIL timeout_rddata got %h want deadbeef", d);
    else n_pass++;
    csr_read(6'h10, d, v);
    n_chk++;
    if (d !== 64'h2_0002)
      $display("FAIL timeout_flag got %h want 20002", d);
    else n_pass++;
`else
    repeat (20) @(negedge clk);
    n_chk++;
    if (avmm_read !== 1'b1)
      $display("FAIL no_timeout_wait got %b want 1", avmm_read);
    else n_pass++;
    csr_read(6'h10, d, v);
    n_chk++;
    if (d[17] !== 1'b0 || d[16] !== 1'b1)
      $display("FAIL no_timeout_flag got err=%b busy=%b want 0 1", d[17], d[16]);
    else n_pass++;
    rst_n = 1'b0;
    avmm_waitrequest = 1'b0;
    release_reset();
`endif
  endtask

  task automatic test_reset_mid();
    logic [63:0] d;
    logic v;
    avmm_waitrequest = 1'b0;
    csr_write(6'h10, 64'h202);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({avmm_write, avmm_read, avmm_address, avmm_writedata,
         csr_rvalid, csr_rdata} !== '0)
      $display("FAIL midreset_out got r=%b a=%0d rd=%h want 0",
               avmm_read, avmm_address, csr_rdata);
    else n_pass++;
    release_reset();
    avmm_readdatavalid = 1'b1;
    avmm_readdata      = 32'h9999_9999;
    @(negedge clk);
    avmm_readdatavalid = 1'b0;
    csr_read(6'h18, d, v);
    n_chk++;
    if (d !== 64'h0) $display("FAIL late_rdv got %h want 0", d);
    else n_pass++;
    csr_read(6'h10, d, v);
    n_chk++;
    if (d !== 64'h0 || avmm_read !== 1'b0)
      $display("FAIL midreset_idle got %h r=%b want 0 0", d, avmm_read);
    else n_pass++;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    wr_acc = 0;
    rd_acc = 0;
    rst_n = 1'b0;
    csr_wr = 1'b0;
    csr_rd = 1'b0;
    csr_addr = '0;
    csr_wdata = '0;
    avmm_waitrequest = 1'b0;
    avmm_readdata = '0;
    avmm_readdatavalid = 1'b0;
    test_reset();
    test_csr_regs();
    test_write();
    test_read();
    test_drop();
    test_conflict();
    test_wd_while_busy();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
